// File: rtl/jt51_pkg.sv
// Shared constants and helpers for the jt51 operator slot pipeline.
package jt51_pkg;

    localparam int N_SLOTS = 32;
    localparam int N_CH    = 8;

    // Operator group, the upper two bits of a slot number.
    typedef enum logic [1:0] {
        GRP_M1 = 2'd0,
        GRP_M2 = 2'd1,
        GRP_C1 = 2'd2,
        GRP_C2 = 2'd3
    } grp_e;

    // Reorders register 0x08 key bits {C2,M2,C1,M1} into group order, so
    // bit g of the result is the key bit for group g. M2 and C1 swap places.
    function automatic logic [3:0] mask_to_grp(input logic [3:0] mask);
        logic [3:0] grp_bits;
        grp_bits[GRP_M1] = mask[0];
        grp_bits[GRP_C1] = mask[1];
        grp_bits[GRP_M2] = mask[2];
        grp_bits[GRP_C2] = mask[3];
        return grp_bits;
    endfunction

endpackage

// File: rtl/jt51_sh.sv
// Clock-enabled shift register: din_i reappears on drop_o STAGES cen-cycles later.
module jt51_sh #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] drop_o
);

    logic [WIDTH-1:0] sr_q [STAGES];

    // Shift one stage per enabled clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these stages are flip-flops rather than a RAM, so clearing them in reset is cheap and keeps stale pulses from leaking out after reset.
            for (int i = 0; i < STAGES; i++) sr_q[i] <= '0;
        end else if (cen_i) begin
            sr_q[0] <= din_i;
            for (int i = 1; i < STAGES; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign drop_o = sr_q[STAGES-1];

endmodule

// File: rtl/jt51_kon_sched.sv
// Key-on scheduler: runs the 32-slot counter, holds CPU key requests and
// commits each operator's key state as its slot enters stage I.
module jt51_kon_sched
    import jt51_pkg::*;
#(
    parameter int PGRST_DLY = 2,
    parameter int KON_DLY   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       kon_we,
    input  logic [2:0] kon_ch,
    input  logic [3:0] kon_mask,
    output logic [4:0] slot_I,
    output logic       zero,
    output logic       kon_I,
    output logic       pg_rst_III,
    output logic       busy
);

    logic [4:0]         slot_q, slot_d;
    logic               zero_q, zero_d;
    logic               kon_q, kon_d;
    logic               edge_q, edge_d;
    logic               busy_q, busy_d;
    logic [N_SLOTS-1:0] req_q, req_d;
    logic [N_SLOTS-1:0] cur_q, cur_d;
    logic [3:0]         grp_bits;

    assign grp_bits = mask_to_grp(kon_mask);

    // Next state: commit the slot being entered, then overlay any CPU write.
    always_comb begin
        // NOTE: every signal gets a default before the conditionals so no path leaves it unassigned, which would infer a latch.
        slot_d = slot_q + 5'd1;
        zero_d = (slot_d == 5'd0);
        kon_d  = kon_q;
        edge_d = edge_q;
        busy_d = busy_q;
        cur_d  = cur_q;
        req_d  = req_q;
        // The commit reads req_q, so a write landing on the same clock as the
        // commit of its slot waits a full revolution instead of being lost.
        if (cen) begin
            cur_d[slot_d] = req_q[slot_d];
            kon_d         = req_q[slot_d];
            edge_d        = req_q[slot_d] & ~cur_q[slot_d];
        end
        if (kon_we) begin
            for (int g = 0; g < 4; g++) req_d[{2'(g), kon_ch}] = grp_bits[g];
        end
        if (cen) busy_d = |(req_d ^ cur_d);
    end

    // Slot-pipeline state advances only on cen; key requests follow every write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= 5'd0;
            zero_q <= 1'b1;
            kon_q  <= 1'b0;
            edge_q <= 1'b0;
            busy_q <= 1'b0;
            req_q  <= '0;
            cur_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values regardless of statement order.
            req_q  <= req_d;
            cur_q  <= cur_d;
            busy_q <= busy_d;
            if (cen) begin
                slot_q <= slot_d;
                zero_q <= zero_d;
                kon_q  <= kon_d;
                edge_q <= edge_d;
            end
        end
    end

    // Delay the key-on edge so the phase reset lines up with stage III.
    generate
        if (PGRST_DLY == 0) begin : g_pg_direct
            assign pg_rst_III = edge_q;
        end else begin : g_pg_delay
            jt51_sh #(.WIDTH(1), .STAGES(PGRST_DLY)) u_pg_sh (
                .clk    (clk),
                .rst_n  (rst_n),
                .cen_i  (cen),
                .din_i  (edge_q),
                .drop_o (pg_rst_III)
            );
        end
    endgenerate

    // Optional extra alignment of the key level towards the envelope generator.
    generate
        if (KON_DLY == 0) begin : g_kon_direct
            assign kon_I = kon_q;
        end else begin : g_kon_delay
            jt51_sh #(.WIDTH(1), .STAGES(KON_DLY)) u_kon_sh (
                .clk    (clk),
                .rst_n  (rst_n),
                .cen_i  (cen),
                .din_i  (kon_q),
                .drop_o (kon_I)
            );
        end
    endgenerate

    assign slot_I = slot_q;
    assign zero   = zero_q;
    assign busy   = busy_q;

endmodule

// File: doc/jt51_kon_sched.md
Name: jt51_kon_sched

Overview:
- Key-on scheduler and slot sequencer for the time-multiplexed operator pipeline: 32 operator slots, one slot per enabled clock.
- Generates the global slot counter and the `zero` marker.
- Latches CPU key-on writes (register 0x08 semantics) and applies each operator's key state when that operator's slot passes stage I.
- Emits the per-slot key-on level for the envelope generator and the phase-reset pulse `pg_rst_III`, aligned to the phase generator's stage III.

Parameters:
- PGRST_DLY, 2: cen-cycles from stage-I evaluation of a slot to assertion of `pg_rst_III` for that slot.
- KON_DLY, 0: extra cen-cycles of delay on `kon_I` relative to `slot_I`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- cen  in  1  clock enable; all state advances only when high
- kon_we  in  1  one-clk write strobe for the key-on register
- kon_ch  in  3  channel number 0..7
- kon_mask  in  4  operator key bits {C2,M2,C1,M1}, as data bits 6..3 of register 0x08
- slot_I  out  5  slot currently at stage I, 0..31
- zero  out  1  high while `slot_I`==0
- kon_I  out  1  committed key state of the slot at stage I
- pg_rst_III  out  1  phase reset for the slot at stage III (key-off→on edge)
- busy  out  1  high while any request differs from the committed state

Behaviour:
- Reset (async, `rst_n`=0):
  - `slot_I`=0, `zero`=1, `kon_I`=0, `pg_rst_III`=0, `busy`=0.
  - `kon_req[31:0]`=0, `kon_cur[31:0]`=0, and all delay-line stages cleared.
  - Reset mid-write discards the write.
- Slot map: slot = {grp[1:0], ch[2:0]}. Group 0=M1, 1=M2, 2=C1, 3=C2.
  - Mask mapping: `kon_mask[0]`→grp0, `[1]`→grp2 (C1), `[2]`→grp1 (M2), `[3]`→grp3.
- Counter: on each cen, `slot_I` <= `slot_I`+1 mod 32 (31→0 wrap). `zero` is registered alongside `slot_I`. With cen=0, everything holds.
- Write path:
  - `kon_we` is sampled on any clk edge, independent of cen.
  - It overwrites the 4 `kon_req` bits of channel `kon_ch` (slots ch, ch+8, ch+16, ch+24). Other channels are untouched.
  - Last write wins; repeated writes before commit leave no residue.
- Commit: on cen, for s=`slot_I`:
  - `kon_cur[s]` <= `kon_req[s]`.
  - `edge` = `kon_req[s]` & ~`kon_cur[s]`.
  - Registered `kon_I` = `kon_req[s]` (the value committed this cycle).
- Simultaneous write and commit of the same slot:
  - Commit uses the pre-write `kon_req` value.
  - The new value commits one revolution (32 cen) later.
  - `kon_req` is never lost.
- `pg_rst_III`: `edge` passed through a PGRST_DLY-stage cen shift register.
  - It is high for exactly one cen-cycle, when the slot equal to (`slot_I` − PGRST_DLY) mod 32 is at stage III.
  - Key-off (1→0) and held states (1→1, 0→0) give no pulse.
- `busy` = |(`kon_req` ^ `kon_cur`), registered. Worst-case latency from write to `busy`=0 is 33 cen.
- Widths: counter 5 bits with natural wrap; no arithmetic beyond increment.

Decomposition:
- Shared package jt51_pkg holds:
  - constants N_SLOTS=32 and N_CH=8;
  - group encodings GRP_M1=0, GRP_M2=1, GRP_C1=2, GRP_C2=3;
  - the `kon_mask`→group mapping function.
- One sub-module: a cen-gated 1-bit delay line for the `pg_rst` alignment, implemented by instantiating the existing jt51_sh (width 1, stages PGRST_DLY).

Test Plan:
- Reset, then cen held high → `slot_I` runs 0..31..0; `zero`=1 only when `slot_I`=0, i.e. every 32 cen; `kon_I`=0; `pg_rst_III` never asserts.
- Write ch=3, mask=4'b0001 while `slot_I`=10 → `busy`=1; at `slot_I`=3 of the next revolution, `kon_I`=1, `kon_cur[3]` set, `pg_rst_III` pulses 2 cen later (`slot_I`=5); `busy` then falls.
- Write ch=5, mask=4'b1111, then after one full revolution write ch=5, mask=4'b1111 again → no further `pg_rst_III` pulses; `kon_I`=1 at slots 5, 13, 21, 29 every revolution.
- Write ch=0, mask=4'b0010 exactly on the cen where `slot_I`=16 → slot 16 not committed this pass (`kon_I`=0); commits on the next pass with `pg_rst_III` at `slot_I`=18.
- Write ch=2 key-on, then before commit write ch=2, mask=0 → no `kon_I`, no `pg_rst_III`; `busy` returns to 0 without any slot change.
- Hold cen=0 for 100 clk with a `kon_we` during the stall → `slot_I` frozen and outputs unchanged, but `kon_req` updated; commit occurs normally after cen resumes. Assert `rst_n` low mid-sequence → all outputs return to reset values immediately.
